truth_table_scanner: RTL and testbench
======================================

Name: truth_table_scanner

Overview:
- Sequential driver/reader for a 4-input combinational gate-level function under test (FUT).
- Walks every input minterm in ascending order on `drive` and samples the FUT output on `f_in` after a programmable settle time.
- Builds the minterm mask and ones count, then compares the mask against an expected mask.
- Sits in the exercises test harness beside each minimized circuit. It is the stimulus/capture end of the FUT's input/output interface.

Parameters:
- N_IN, 4, number of FUT inputs; minterm count M = 2^N_IN.
- SETTLE, 1, cycles `drive` is held before the sampling cycle; legal range 1..255.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  scan request; sampled only in IDLE.
- f_in  input  1  FUT output.
- expected  input  M  reference minterm mask; sampled in the SAMPLE cycle of the last minterm.
- drive  output  N_IN  FUT input vector; bit N_IN-1 = A (MSB), bit 0 = D.
- busy  output  1  high from the edge after start is accepted until DONE is left.
- done  output  1  one-cycle pulse, scan complete.
- tt  output  M  captured mask; bit i = f_in observed with drive = i.
- ones  output  N_IN+1  number of set bits in tt.
- match  output  1  registered (tt == expected); valid from done, held until next start.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset values: state = IDLE; drive, busy, done, tt, ones, match, minterm index idx, and wait counter all = 0.
- States: IDLE, WAIT, SAMPLE, DONE.
- IDLE:
  - busy = 0, drive = 0.
  - If start = 1 at an edge: clear tt, ones, match; set idx = 0 and wait_cnt = 0; go to WAIT.
- WAIT:
  - drive = idx, busy = 1.
  - wait_cnt increments each edge.
  - When wait_cnt = SETTLE-1 at an edge, go to SAMPLE.
- SAMPLE:
  - drive = idx, held stable.
  - At the edge: tt[idx] <= f_in; ones <= ones + f_in.
  - If idx = M-1: match <= ({f_in, tt[M-2:0]} == expected), i.e. computed on the updated mask; go to DONE.
  - Otherwise: idx <= idx+1, wait_cnt <= 0, go to WAIT.
- DONE:
  - done = 1 and busy = 1 for exactly one cycle; drive = M-1.
  - Next edge returns to IDLE unconditionally.
- Latency: each minterm takes SETTLE+1 cycles.
  - done is high in the cycle after edge number M*(SETTLE+1), counting the start-accepting edge as edge 0.
  - Example: N_IN=4, SETTLE=1 gives done after edge 32.
- start while not in IDLE is ignored; no queuing.
- start held continuously:
  - One scan per IDLE visit; a new scan is accepted on the edge leaving IDLE.
  - IDLE therefore lasts exactly one cycle between scans.
- tt, ones, match hold their final values after DONE until the next accepted start clears them.
- Width rules:
  - ones never wraps; the maximum M fits in N_IN+1 bits.
  - idx is N_IN bits; increment from M-1 never occurs.
- rst asserted mid-scan: all state and outputs go to reset values at that edge; no done pulse is emitted for the aborted scan.
- rst and start high at the same edge: reset wins.

Test Plan:
1. FUT model F = A(CD+B) + BC' on drive, expected = 0xF830, N_IN=4, SETTLE=1, pulse start → drive steps 0..15 with each value held 2 cycles; done after edge 32; tt = 0xF830, ones = 7, match = 1; busy falls the cycle after done.
2. f_in tied 0, expected = 0xF830 → tt = 0x0000, ones = 0, match = 0. Then f_in tied 1, expected = 0xFFFF, rescan → tt = 0xFFFF, ones = 16, match = 1.
3. Pulse start, then re-pulse start at edges 5 and 20 → ignored; exactly one done pulse at edge 32. Then hold start high continuously → next scan accepted on the edge after DONE→IDLE, with tt cleared to 0 at that edge.
4. Assert rst for one cycle at edge 15 (idx = 7) → next cycle drive = 0, busy = 0, tt = 0, ones = 0, state IDLE; no done pulse within 40 further cycles.
5. SETTLE=3, FUT = 2-cycle registered model of F → tt = 0xF830 (proves settle wait); each drive value held 4 cycles; done after edge 64.
6. Back-to-back scans with expected changed from 0xF830 to 0x0000 between them → first scan match = 1; second scan match = 0, while tt is still 0xF830 and ones = 7.

Source files
------------

// File: rtl/truth_table_scanner_if.sv
// Stimulus/capture bundle between a truth-table scanner and its test harness.
// The slave side is the scanner; the master side supplies the FUT output and the reference mask.
interface truth_table_scanner_if #(
    parameter int N_IN = 4
);
    localparam int M = 1 << N_IN;

    logic              start;
    logic              f_in;
    logic [M-1:0]      expected;
    logic [N_IN-1:0]   drive;
    logic              busy;
    logic              done;
    logic [M-1:0]      tt;
    logic [N_IN:0]     ones;
    logic              match;

    modport master (
        output start,
        output f_in,
        output expected,
        input  drive,
        input  busy,
        input  done,
        input  tt,
        input  ones,
        input  match
    );

    modport slave (
        input  start,
        input  f_in,
        input  expected,
        output drive,
        output busy,
        output done,
        output tt,
        output ones,
        output match
    );
endinterface

// File: rtl/truth_table_scanner.sv
// Walks all minterms of an N_IN-input function under test, captures its truth table
// after a programmable settle time, counts the ones and compares against a reference mask.
module truth_table_scanner #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    truth_table_scanner_if.slave  bus
);
    localparam int M = 1 << N_IN;
    localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [N_IN-1:0] IDX_LAST    = {N_IN{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [N_IN-1:0]   idx_reg, idx_next;
    logic [7:0]        wait_cnt_reg, wait_cnt_next;
    logic [M-1:0]      tt_reg, tt_next;
    logic [N_IN:0]     ones_reg, ones_next;
    logic              match_reg, match_next;
    logic [N_IN-1:0]   drive_reg, drive_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;

    logic [M-1:0]      idx_onehot;
    logic [M-1:0]      tt_sampled;

    // Mask as it will look once the current minterm is written in; the final
    // match must see the last sample, not the stale mask.
    assign idx_onehot = {{(M-1){1'b0}}, 1'b1} << idx_reg;

    for (genvar gi = 0; gi < M; gi++) begin : g_capture
        assign tt_sampled[gi] = idx_onehot[gi] ? bus.f_in : tt_reg[gi];
    end

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        wait_cnt_next = wait_cnt_reg;
        tt_next       = tt_reg;
        ones_next     = ones_reg;
        match_next    = match_reg;

        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next    = ST_WAIT;
                    idx_next      = '0;
                    wait_cnt_next = '0;
                    tt_next       = '0;
                    ones_next     = '0;
                    match_next    = 1'b0;
                end
            end
            ST_WAIT: begin
                wait_cnt_next = wait_cnt_reg + 8'd1;
                if (wait_cnt_reg == SETTLE_LAST) begin
                    state_next = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                tt_next   = tt_sampled;
                ones_next = ones_reg + {{N_IN{1'b0}}, bus.f_in};
                if (idx_reg == IDX_LAST) begin
                    match_next = (tt_sampled == bus.expected);
                    state_next = ST_DONE;
                end else begin
                    idx_next      = idx_reg + N_IN'(1);
                    wait_cnt_next = '0;
                    state_next    = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so the FUT sees a glitch-free drive vector.
    always_comb begin
        drive_next = '0;
        busy_next  = 1'b0;
        done_next  = 1'b0;
        if (state_next != ST_IDLE) begin
            drive_next = idx_next;
            busy_next  = 1'b1;
        end
        if (state_next == ST_DONE) begin
            done_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            idx_reg      <= '0;
            wait_cnt_reg <= '0;
            tt_reg       <= '0;
            ones_reg     <= '0;
            match_reg    <= 1'b0;
            drive_reg    <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            wait_cnt_reg <= wait_cnt_next;
            tt_reg       <= tt_next;
            ones_reg     <= ones_next;
            match_reg    <= match_next;
            drive_reg    <= drive_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    assign bus.drive = drive_reg;
    assign bus.busy  = busy_reg;
    assign bus.done  = done_reg;
    assign bus.tt    = tt_reg;
    assign bus.ones  = ones_reg;
    assign bus.match = match_reg;
endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed and randomized scans of truth_table_scanner with SETTLE=1 and SETTLE=3 instances,
// checked against a truth-table reference model built from the FUT definitions.
module tb_truth_table_scanner;
    localparam int N_IN = 4;
    localparam int M    = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    truth_table_scanner_if #(.N_IN(N_IN)) bus1 ();
    truth_table_scanner_if #(.N_IN(N_IN)) bus3 ();

    truth_table_scanner #(.N_IN(N_IN), .SETTLE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    truth_table_scanner #(.N_IN(N_IN), .SETTLE(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    int vectors     = 0;
    int miscompares = 0;
    int scan_no     = 0;

    // FUT selection for the SETTLE=1 instance: 0 = F, 1 = const 0, 2 = const 1, 3 = random table
    int          fut_mode = 0;
    logic [15:0] rand_tbl = 16'h0000;

    // F = A(CD + B) + BC', A = drive[3] ... D = drive[0]
    function automatic logic f_ref(input logic [3:0] v);
        logic a, b, c, d;
        a = v[3]; b = v[2]; c = v[1]; d = v[0];
        return (a & ((c & d) | b)) | (b & ~c);
    endfunction

    function automatic logic fut_val(input int mode, input int i, input logic [15:0] tbl);
        case (mode)
            0:       return f_ref(4'(i));
            1:       return 1'b0;
            2:       return 1'b1;
            default: return tbl[i];
        endcase
    endfunction

    function automatic logic [15:0] ref_mask(input int mode, input logic [15:0] tbl);
        logic [15:0] m;
        m = '0;
        for (int i = 0; i < M; i++) m[i] = fut_val(mode, i, tbl);
        return m;
    endfunction

    function automatic int ref_ones(input logic [15:0] m);
        int n;
        n = 0;
        for (int i = 0; i < M; i++) if (m[i]) n++;
        return n;
    endfunction

    assign bus1.f_in = fut_val(fut_mode, int'(bus1.drive), rand_tbl);

    // Two-cycle registered copy of F for the SETTLE=3 instance
    logic fut_r1 = 1'b0;
    logic fut_r2 = 1'b0;
    always @(posedge clk) begin
        fut_r1 <= f_ref(bus3.drive);
        fut_r2 <= fut_r1;
    end
    assign bus3.f_in = fut_r2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full scan on the SETTLE=1 instance; start is re-pulsed at edges g1/g2 (0 = none).
    task automatic do_scan(input string name, input logic [15:0] exp_mask,
                           input int g1, input int g2);
        int          done_cnt;
        int          done_edge;
        logic [15:0] rtt;
        done_cnt  = 0;
        done_edge = -1;
        bus1.expected = exp_mask;
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        check({name, "_busy_on"}, 32'(bus1.busy), 32'd1);
        check({name, "_tt_clr"},  32'(bus1.tt),   32'd0);
        for (int e = 1; e <= 33; e++) begin
            bus1.start = (e == g1) || (e == g2);
            tick();
            if (bus1.done) begin
                done_cnt++;
                done_edge = e;
            end
            if (e < 32) check({name, "_drive"}, 32'(bus1.drive), 32'(e / 2));
            if (e == 32) begin
                check({name, "_done"},      32'(bus1.done),  32'd1);
                check({name, "_busy_done"}, 32'(bus1.busy),  32'd1);
                check({name, "_drive_end"}, 32'(bus1.drive), 32'd15);
            end
        end
        bus1.start = 1'b0;
        rtt = ref_mask(fut_mode, rand_tbl);
        check({name, "_done_cnt"},  32'(done_cnt),   32'd1);
        check({name, "_done_edge"}, 32'(done_edge),  32'd32);
        check({name, "_busy_off"},  32'(bus1.busy),  32'd0);
        check({name, "_drive_idle"},32'(bus1.drive), 32'd0);
        check({name, "_tt"},        32'(bus1.tt),    32'(rtt));
        check({name, "_ones"},      32'(bus1.ones),  32'(ref_ones(rtt)));
        check({name, "_match"},     32'(bus1.match), 32'(rtt == exp_mask));
        scan_no++;
        $display("scan %0d %s: expected=%h tt=%h ones=%0d match=%b",
                 scan_no, name, exp_mask, bus1.tt, bus1.ones, bus1.match);
    endtask

    initial begin
        int          cnt;
        int          busy_seen;
        logic [15:0] e_mask;

        rst = 1'b1;
        bus1.start = 1'b0; bus1.expected = 16'h0000;
        bus3.start = 1'b0; bus3.expected = 16'hF830;
        repeat (3) tick();
        check("rst_drive", 32'(bus1.drive), 32'd0);
        check("rst_busy",  32'(bus1.busy),  32'd0);
        check("rst_done",  32'(bus1.done),  32'd0);
        check("rst_tt",    32'(bus1.tt),    32'd0);
        check("rst_ones",  32'(bus1.ones),  32'd0);
        check("rst_match", 32'(bus1.match), 32'd0);
        check("rst3_busy", 32'(bus3.busy),  32'd0);

        // Reset wins over a simultaneous start
        bus1.start = 1'b1;
        tick();
        check("rst_start_busy", 32'(bus1.busy), 32'd0);
        rst = 1'b0;
        bus1.start = 1'b0;
        tick();
        check("rst_start_idle", 32'(bus1.busy), 32'd0);

        // 1: function F
        fut_mode = 0;
        do_scan("f_basic", 16'hF830, 0, 0);
        check("f_basic_tt_const",   32'(bus1.tt),   32'h0000F830);
        check("f_basic_ones_const", 32'(bus1.ones), 32'd7);

        // 2: constant outputs
        fut_mode = 1;
        do_scan("const0", 16'hF830, 0, 0);
        fut_mode = 2;
        do_scan("const1", 16'hFFFF, 0, 0);
        check("const1_ones16", 32'(bus1.ones), 32'd16);

        // 3: start re-pulsed mid-scan, then held continuously
        fut_mode = 0;
        do_scan("ignore_start", 16'hF830, 5, 20);
        bus1.start = 1'b1;
        tick();
        for (int e = 1; e <= 33; e++) begin
            tick();
            if (e == 32) check("hold_done", 32'(bus1.done), 32'd1);
        end
        check("hold_idle_busy", 32'(bus1.busy), 32'd0);
        check("hold_idle_tt",   32'(bus1.tt),   32'h0000F830);
        tick();
        check("hold_rescan_busy",  32'(bus1.busy),  32'd1);
        check("hold_rescan_tt",    32'(bus1.tt),    32'd0);
        check("hold_rescan_ones",  32'(bus1.ones),  32'd0);
        check("hold_rescan_match", 32'(bus1.match), 32'd0);
        bus1.start = 1'b0;
        cnt = 0;
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (bus1.done) begin
                cnt = e;
                break;
            end
        end
        check("hold_second_done_edge", 32'(cnt), 32'd32);
        tick();
        $display("scan hold: tt=%h ones=%0d match=%b", bus1.tt, bus1.ones, bus1.match);

        // 4: reset during minterm 7
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        for (int e = 1; e <= 14; e++) tick();
        check("abort_drive_pre", 32'(bus1.drive), 32'd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_drive", 32'(bus1.drive), 32'd0);
        check("abort_busy",  32'(bus1.busy),  32'd0);
        check("abort_tt",    32'(bus1.tt),    32'd0);
        check("abort_ones",  32'(bus1.ones),  32'd0);
        cnt = 0;
        busy_seen = 0;
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (bus1.done) cnt++;
            if (bus1.busy) busy_seen++;
        end
        check("abort_no_done", 32'(cnt),       32'd0);
        check("abort_no_busy", 32'(busy_seen), 32'd0);
        $display("scan abort: done pulses=%0d", cnt);

        // 5: SETTLE=3 against a two-cycle registered FUT
        bus3.start = 1'b1;
        tick();
        bus3.start = 1'b0;
        cnt = 0;
        for (int e = 1; e <= 65; e++) begin
            tick();
            if (bus3.done) cnt++;
            if (e < 64) check("s3_drive", 32'(bus3.drive), 32'(e / 4));
            if (e == 64) check("s3_done", 32'(bus3.done), 32'd1);
        end
        check("s3_done_cnt", 32'(cnt),        32'd1);
        check("s3_busy_off", 32'(bus3.busy),  32'd0);
        check("s3_tt",       32'(bus3.tt),    32'(ref_mask(0, 16'h0)));
        check("s3_ones",     32'(bus3.ones),  32'd7);
        check("s3_match",    32'(bus3.match), 32'd1);
        $display("scan settle3: tt=%h ones=%0d match=%b", bus3.tt, bus3.ones, bus3.match);

        // 6: back-to-back scans with the reference changed in between
        fut_mode = 0;
        do_scan("b2b_first", 16'hF830, 0, 0);
        check("b2b_first_match", 32'(bus1.match), 32'd1);
        do_scan("b2b_second", 16'h0000, 0, 0);
        check("b2b_second_match", 32'(bus1.match), 32'd0);
        check("b2b_second_tt",    32'(bus1.tt),    32'h0000F830);
        check("b2b_second_ones",  32'(bus1.ones),  32'd7);

        // Randomized truth tables, reference matching about half the time
        fut_mode = 3;
        for (int k = 0; k < 8; k++) begin
            rand_tbl = 16'($urandom);
            e_mask   = ($urandom_range(0, 1) == 1) ? rand_tbl : 16'($urandom);
            do_scan("random", e_mask, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
